// File: rtl/bpc_dec_pkg.sv
// Shared widths, thresholds and feeder state encoding for the bit-plane decoder stream path.
package bpc_dec_pkg;

    localparam int unsigned CODE_BUF_W = 128;
    localparam int unsigned BUF_SIZE_W = 7;
    localparam int unsigned ZRL_W      = 4;
    localparam int unsigned LANES      = 4;
    localparam int unsigned PLANE_W    = 63;
    localparam int unsigned REFILL_TH  = 95;

    typedef enum logic [0:0] {
        ST_ACTIVE = 1'b0,
        ST_SKIP   = 1'b1
    } feed_state_e;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/dec_buf_merge.sv
// Inserts one stream word into the MSB-aligned code buffer directly below the valid residual bits.
module dec_buf_merge
    import bpc_dec_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic [CODE_BUF_W-1:0] base_buf,
    input  logic [WORD_W-1:0]     word,
    input  logic [BUF_SIZE_W-1:0] offset,
    output logic [CODE_BUF_W-1:0] merged
);

    logic [CODE_BUF_W-1:0] aligned;

    assign aligned = {word, {(CODE_BUF_W-WORD_W){1'b0}}};
    assign merged  = base_buf | (aligned >> offset);

endmodule

// File: rtl/decoder_stream_feeder.sv
// Refill/alignment stage feeding DECODER_GROUP: word packing, lane masking, pad handling, frame tracking.
// Optional sticky error detection is built only when DEC_FEEDER_ERR_CHECK_EN is defined.
module decoder_stream_feeder
    import bpc_dec_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned PLANES = 33
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WORD_W-1:0]     s_data_i,
    input  logic                  s_valid_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    output logic [CODE_BUF_W-1:0] grp_code_buf_o,
    output logic [BUF_SIZE_W-1:0] grp_buf_size_o,
    output logic [ZRL_W-1:0]      grp_zrl_cnt_o,
    input  logic [CODE_BUF_W-1:0] grp_code_buf_i,
    input  logic [BUF_SIZE_W-1:0] grp_buf_size_i,
    input  logic [ZRL_W-1:0]      grp_zrl_cnt_i,
    input  logic [LANES-1:0]      grp_valid_i,
    output logic [LANES-1:0]      lane_valid_o,
    input  logic                  out_ready_i,
    output logic                  frame_done_o,
    output logic                  err_o
);

    localparam logic [7:0] PLANES_C = 8'(PLANES);

    feed_state_e           state_q, state_d;
    logic [CODE_BUF_W-1:0] code_buf_q, code_buf_d;
    logic [BUF_SIZE_W-1:0] size_q, size_d;
    logic [ZRL_W-1:0]      zrl_q, zrl_d;
    logic [7:0]            plane_cnt_q, plane_cnt_d;
    logic                  last_seen_q, last_seen_d;
    logic                  frame_done_q, frame_done_d;

    logic                  pad;
    logic [8:0]            rem;
    logic                  lanes_none;
    logic                  commit;
    logic [BUF_SIZE_W-1:0] grp_size_adj;
    logic [CODE_BUF_W-1:0] cbuf;
    logic [BUF_SIZE_W-1:0] csize;
    logic [7:0]            plane_nxt;
    logic                  accept;
    logic                  planes_done;
    logic                  last_eff;
    logic [CODE_BUF_W-1:0] merged;

    assign pad            = last_seen_q & (size_q != 7'd127);
    assign grp_buf_size_o = size_q + {6'd0, pad};
    assign grp_code_buf_o = code_buf_q;
    assign grp_zrl_cnt_o  = zrl_q;
    assign frame_done_o   = frame_done_q;

    assign rem = 9'(PLANES) - {1'b0, plane_cnt_q};

    always_comb begin
        lane_valid_o = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_valid_o[LANES-1-k] = grp_valid_i[LANES-1-k] & (rem > 9'(k));
        end
    end

    // Commit is held off in SKIP: the buffer only carries pad there and is cleared on s_last_i.
    assign lanes_none   = (lane_valid_o == '0);
    assign commit       = (state_q == ST_ACTIVE) & (out_ready_i | lanes_none);
    assign grp_size_adj = (grp_buf_size_i > {6'd0, pad}) ? grp_buf_size_i - {6'd0, pad} : '0;
    assign cbuf         = commit ? grp_code_buf_i : code_buf_q;
    assign csize        = commit ? grp_size_adj : size_q;
    assign plane_nxt    = plane_cnt_q + {5'd0, popcount4(lane_valid_o)};

    assign s_ready_o = ~rst_i & ((state_q == ST_SKIP) |
                       ((state_q == ST_ACTIVE) & ~last_seen_q & (csize <= 7'(REFILL_TH))));
    assign accept    = s_valid_i & s_ready_o;

    // A last word accepted in the completing cycle is pad only, so it finishes the frame too.
    assign planes_done = commit & (plane_nxt == PLANES_C);
    assign last_eff    = last_seen_q | (accept & s_last_i);

    dec_buf_merge #(
        .WORD_W(WORD_W)
    ) u_merge (
        .base_buf(cbuf),
        .word    (s_data_i),
        .offset  (csize),
        .merged  (merged)
    );

    always_comb begin
        state_d      = state_q;
        code_buf_d   = code_buf_q;
        size_d       = size_q;
        zrl_d        = zrl_q;
        plane_cnt_d  = plane_cnt_q;
        last_seen_d  = last_seen_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (commit) begin
                    code_buf_d  = cbuf;
                    size_d      = csize;
                    zrl_d       = grp_zrl_cnt_i;
                    plane_cnt_d = plane_nxt;
                end
                if (accept) begin
                    code_buf_d  = merged;
                    size_d      = csize + 7'd32;
                    last_seen_d = last_seen_q | s_last_i;
                end
                if (planes_done) begin
                    if (last_eff) begin
                        code_buf_d   = '0;
                        size_d       = '0;
                        zrl_d        = '0;
                        plane_cnt_d  = '0;
                        last_seen_d  = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                if (accept & s_last_i) begin
                    code_buf_d   = '0;
                    size_d       = '0;
                    zrl_d        = '0;
                    plane_cnt_d  = '0;
                    last_seen_d  = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = ST_ACTIVE;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_ACTIVE;
            code_buf_q   <= '0;
            size_q       <= '0;
            zrl_q        <= '0;
            plane_cnt_q  <= '0;
            last_seen_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_buf_q   <= code_buf_d;
            size_q       <= size_d;
            zrl_q        <= zrl_d;
            plane_cnt_q  <= plane_cnt_d;
            last_seen_q  <= last_seen_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef DEC_FEEDER_ERR_CHECK_EN
    logic err_q;
    logic err_set;

    assign err_set = ((state_q == ST_ACTIVE) & last_seen_q & lanes_none &
                      (plane_cnt_q < PLANES_C) & (zrl_q == '0)) |
                     (planes_done & (grp_zrl_cnt_i != '0));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | err_set;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_stream_feeder.sv
// Directed bench for decoder_stream_feeder; the bench stands in for DECODER_GROUP.
module tb_decoder_stream_feeder;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [31:0]  s_data_i;
    logic         s_valid_i;
    logic         s_last_i;
    logic         s_ready_o;
    logic [127:0] grp_code_buf_o;
    logic [6:0]   grp_buf_size_o;
    logic [3:0]   grp_zrl_cnt_o;
    logic [127:0] grp_code_buf_i;
    logic [6:0]   grp_buf_size_i;
    logic [3:0]   grp_zrl_cnt_i;
    logic [3:0]   grp_valid_i;
    logic [3:0]   lane_valid_o;
    logic         out_ready_i;
    logic         frame_done_o;
    logic         err_o;

    // Group model: pass-through (decodes nothing) or bench-forced result.
    logic         pass;
    logic [127:0] f_buf;
    logic [6:0]   f_size;
    logic [3:0]   f_zrl;
    logic [3:0]   f_valid;

    assign grp_code_buf_i = pass ? grp_code_buf_o : f_buf;
    assign grp_buf_size_i = pass ? grp_buf_size_o : f_size;
    assign grp_zrl_cnt_i  = pass ? grp_zrl_cnt_o  : f_zrl;
    assign grp_valid_i    = pass ? 4'b0000 : f_valid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] x_buf, y_buf, r_buf, exp_buf, tmp;

    always #5 clk = ~clk;

    decoder_stream_feeder #(
        .WORD_W(32),
        .PLANES(4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .s_data_i      (s_data_i),
        .s_valid_i     (s_valid_i),
        .s_last_i      (s_last_i),
        .s_ready_o     (s_ready_o),
        .grp_code_buf_o(grp_code_buf_o),
        .grp_buf_size_o(grp_buf_size_o),
        .grp_zrl_cnt_o (grp_zrl_cnt_o),
        .grp_code_buf_i(grp_code_buf_i),
        .grp_buf_size_i(grp_buf_size_i),
        .grp_zrl_cnt_i (grp_zrl_cnt_i),
        .grp_valid_i   (grp_valid_i),
        .lane_valid_o  (lane_valid_o),
        .out_ready_i   (out_ready_i),
        .frame_done_o  (frame_done_o),
        .err_o         (err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; s_valid_i = 1'b0; s_last_i = 1'b0; s_data_i = '0;
        out_ready_i = 1'b1; pass = 1'b1;
        f_buf = '0; f_size = '0; f_zrl = '0; f_valid = '0;
        tick(); tick();
        n_cmp++; if (s_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", s_ready_o); end
        n_cmp++; if (grp_code_buf_o !== 128'h0) begin n_bad++; $display("FAIL reset_buf: got %h want 0", grp_code_buf_o); end
        n_cmp++; if (grp_buf_size_o !== 7'd0) begin n_bad++; $display("FAIL reset_size: got %0d want 0", grp_buf_size_o); end
        n_cmp++; if (grp_zrl_cnt_o !== 4'd0) begin n_bad++; $display("FAIL reset_zrl: got %0d want 0", grp_zrl_cnt_o); end
        n_cmp++; if (frame_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", frame_done_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
        rst_i = 1'b0;
        #1;
        n_cmp++; if (s_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", s_ready_o); end
    endtask

    task automatic test_single_frame();
        s_data_i = 32'h2492_4000; s_valid_i = 1'b1; s_last_i = 1'b1;
        #1;
        n_cmp++; if (s_ready_o !== 1'b1) begin n_bad++; $display("FAIL sf_ready: got %b want 1", s_ready_o); end
        tick();
        s_valid_i = 1'b0; s_last_i = 1'b0;
        n_cmp++; if (grp_code_buf_o !== {32'h2492_4000, 96'h0}) begin n_bad++; $display("FAIL sf_buf: got %h want %h", grp_code_buf_o, {32'h2492_4000, 96'h0}); end
        n_cmp++; if (grp_buf_size_o !== 7'd33) begin n_bad++; $display("FAIL sf_size_pad: got %0d want 33", grp_buf_size_o); end
        n_cmp++; if (s_ready_o !== 1'b0) begin n_bad++; $display("FAIL sf_ready_after_last: got %b want 0", s_ready_o); end
        pass = 1'b0; f_buf = {32'h2400_0000, 96'h0}; f_size = 7'd21; f_zrl = '0; f_valid = 4'b1111;
        #1;
        n_cmp++; if (lane_valid_o !== 4'b1111) begin n_bad++; $display("FAIL sf_lanes: got %b want 1111", lane_valid_o); end
        n_cmp++; if (frame_done_o !== 1'b0) begin n_bad++; $display("FAIL sf_done_early: got %b want 0", frame_done_o); end
        tick();
        n_cmp++; if (frame_done_o !== 1'b1) begin n_bad++; $display("FAIL sf_done: got %b want 1", frame_done_o); end
        n_cmp++; if (grp_code_buf_o !== 128'h0) begin n_bad++; $display("FAIL sf_buf_clear: got %h want 0", grp_code_buf_o); end
        n_cmp++; if (grp_buf_size_o !== 7'd0) begin n_bad++; $display("FAIL sf_size_clear: got %0d want 0", grp_buf_size_o); end
        pass = 1'b1; f_valid = '0;
        tick();
        n_cmp++; if (frame_done_o !== 1'b0) begin n_bad++; $display("FAIL sf_done_pulse: got %b want 0", frame_done_o); end
        n_cmp++; if (s_ready_o !== 1'b1) begin n_bad++; $display("FAIL sf_ready_next: got %b want 1", s_ready_o); end
    endtask

    task automatic test_stall_and_mask();
        x_buf = {32'hFFFF_FE00, 96'h0};
        y_buf = {32'hF800_0000, 96'h0};
        s_data_i = 32'hFFFF_FFFF; s_valid_i = 1'b1; s_last_i = 1'b0;
        tick();
        s_valid_i = 1'b0;
        n_cmp++; if (grp_buf_size_o !== 7'd32) begin n_bad++; $display("FAIL st_size_nopad: got %0d want 32", grp_buf_size_o); end
        pass = 1'b0; f_buf = x_buf; f_size = 7'd23; f_zrl = '0; f_valid = 4'b1110;
        #1;
        n_cmp++; if (lane_valid_o !== 4'b1110) begin n_bad++; $display("FAIL st_lanes3: got %b want 1110", lane_valid_o); end
        tick();
        f_buf = y_buf; f_size = 7'd5; f_valid = 4'b1111; out_ready_i = 1'b0;
        #1;
        n_cmp++; if (lane_valid_o !== 4'b1000) begin n_bad++; $display("FAIL st_mask_rem1: got %b want 1000", lane_valid_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (grp_code_buf_o !== x_buf) begin n_bad++; $display("FAIL st_hold_buf[%0d]: got %h want %h", i, grp_code_buf_o, x_buf); end
            n_cmp++; if (grp_buf_size_o !== 7'd23) begin n_bad++; $display("FAIL st_hold_size[%0d]: got %0d want 23", i, grp_buf_size_o); end
            n_cmp++; if (lane_valid_o !== 4'b1000) begin n_bad++; $display("FAIL st_hold_lanes[%0d]: got %b want 1000", i, lane_valid_o); end
        end
        out_ready_i = 1'b1;
        tick();
        n_cmp++; if (grp_buf_size_o !== 7'd5) begin n_bad++; $display("FAIL st_resume_size: got %0d want 5", grp_buf_size_o); end
        n_cmp++; if (s_ready_o !== 1'b1) begin n_bad++; $display("FAIL st_skip_ready: got %b want 1", s_ready_o); end
        n_cmp++; if (lane_valid_o !== 4'b0000) begin n_bad++; $display("FAIL st_skip_mask: got %b want 0000", lane_valid_o); end
        n_cmp++; if (frame_done_o !== 1'b0) begin n_bad++; $display("FAIL st_skip_nodone: got %b want 0", frame_done_o); end
    endtask

    task automatic test_skip();
        s_data_i = 32'h1111_1111; s_valid_i = 1'b1; s_last_i = 1'b0;
        tick();
        n_cmp++; if (frame_done_o !== 1'b0) begin n_bad++; $display("FAIL sk_pad1_done: got %b want 0", frame_done_o); end
        n_cmp++; if (grp_code_buf_o !== y_buf) begin n_bad++; $display("FAIL sk_pad1_drop: got %h want %h", grp_code_buf_o, y_buf); end
        s_data_i = 32'h2222_2222; s_last_i = 1'b1;
        tick();
        s_valid_i = 1'b0; s_last_i = 1'b0;
        n_cmp++; if (frame_done_o !== 1'b1) begin n_bad++; $display("FAIL sk_done: got %b want 1", frame_done_o); end
        n_cmp++; if (grp_code_buf_o !== 128'h0) begin n_bad++; $display("FAIL sk_buf_clear: got %h want 0", grp_code_buf_o); end
        n_cmp++; if (grp_buf_size_o !== 7'd0) begin n_bad++; $display("FAIL sk_size_clear: got %0d want 0", grp_buf_size_o); end
        pass = 1'b1; f_valid = '0;
    endtask

    task automatic test_merge();
        s_data_i = 32'hA5A5_A5A5; s_valid_i = 1'b1;
        tick();
        n_cmp++; if (grp_code_buf_o !== {32'hA5A5_A5A5, 96'h0}) begin n_bad++; $display("FAIL mg_aligned: got %h want %h", grp_code_buf_o, {32'hA5A5_A5A5, 96'h0}); end
        s_data_i = 32'h1234_5678;
        tick();
        s_valid_i = 1'b0;
        n_cmp++; if (grp_code_buf_o !== {32'hA5A5_A5A5, 32'h1234_5678, 64'h0}) begin n_bad++; $display("FAIL mg_two_words: got %h", grp_code_buf_o); end
        n_cmp++; if (grp_buf_size_o !== 7'd64) begin n_bad++; $display("FAIL mg_size64: got %0d want 64", grp_buf_size_o); end
        r_buf = {32'hDEAD_BEEF, 96'h0};
        pass = 1'b0; f_buf = r_buf; f_size = 7'd40; f_zrl = '0; f_valid = 4'b1000;
        s_data_i = 32'hCAFE_F00D; s_valid_i = 1'b1;
        #1;
        n_cmp++; if (s_ready_o !== 1'b1) begin n_bad++; $display("FAIL mg_ready_commit: got %b want 1", s_ready_o); end
        n_cmp++; if (lane_valid_o !== 4'b1000) begin n_bad++; $display("FAIL mg_lane: got %b want 1000", lane_valid_o); end
        tick();
        s_valid_i = 1'b0;
        tmp = {32'hCAFE_F00D, 96'h0};
        exp_buf = r_buf | (tmp >> 40);
        n_cmp++; if (grp_code_buf_o !== exp_buf) begin n_bad++; $display("FAIL mg_post_commit: got %h want %h", grp_code_buf_o, exp_buf); end
        n_cmp++; if (grp_buf_size_o !== 7'd72) begin n_bad++; $display("FAIL mg_size72: got %0d want 72", grp_buf_size_o); end
        f_buf = exp_buf; f_size = 7'd95; f_valid = 4'b0000;
        #1;
        n_cmp++; if (s_ready_o !== 1'b1) begin n_bad++; $display("FAIL mg_ready95: got %b want 1", s_ready_o); end
        f_size = 7'd96;
        #1;
        n_cmp++; if (s_ready_o !== 1'b0) begin n_bad++; $display("FAIL mg_ready96: got %b want 0", s_ready_o); end
        f_size = 7'd95; s_data_i = 32'h0000_0001; s_valid_i = 1'b1;
        tick();
        s_valid_i = 1'b0; pass = 1'b1;
        #1;
        n_cmp++; if (grp_code_buf_o !== (exp_buf | 128'h2)) begin n_bad++; $display("FAIL mg_at95: got %h want %h", grp_code_buf_o, exp_buf | 128'h2); end
        n_cmp++; if (grp_buf_size_o !== 7'd127) begin n_bad++; $display("FAIL mg_size127: got %0d want 127", grp_buf_size_o); end
        n_cmp++; if (s_ready_o !== 1'b0) begin n_bad++; $display("FAIL mg_ready127: got %b want 0", s_ready_o); end
    endtask

    task automatic test_reset_midframe();
        rst_i = 1'b1;
        tick();
        n_cmp++; if (grp_code_buf_o !== 128'h0) begin n_bad++; $display("FAIL mr_buf: got %h want 0", grp_code_buf_o); end
        n_cmp++; if (grp_buf_size_o !== 7'd0) begin n_bad++; $display("FAIL mr_size: got %0d want 0", grp_buf_size_o); end
        n_cmp++; if (frame_done_o !== 1'b0) begin n_bad++; $display("FAIL mr_done: got %b want 0", frame_done_o); end
        n_cmp++; if (s_ready_o !== 1'b0) begin n_bad++; $display("FAIL mr_ready: got %b want 0", s_ready_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_pad_and_trunc();
        pass = 1'b1; s_data_i = 32'h8000_0000; s_valid_i = 1'b1; s_last_i = 1'b1;
        tick();
        s_valid_i = 1'b0; s_last_i = 1'b0;
        pass = 1'b0; f_buf = {32'h4000_0000, 96'h0}; f_size = 7'd20; f_zrl = '0; f_valid = 4'b1000;
        tick();
        n_cmp++; if (grp_buf_size_o !== 7'd20) begin n_bad++; $display("FAIL pd_sub_pad: got %0d want 20", grp_buf_size_o); end
        f_size = 7'd0; f_valid = 4'b0000; f_buf = '0;
        tick();
        n_cmp++; if (grp_buf_size_o !== 7'd1) begin n_bad++; $display("FAIL pd_floor: got %0d want 1", grp_buf_size_o); end
        tick();
`ifdef DEC_FEEDER_ERR_CHECK_EN
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL pd_err_set: got %b want 1", err_o); end
        tick(); tick();
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL pd_err_sticky: got %b want 1", err_o); end
`else
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL pd_err_off: got %b want 0", err_o); end
`endif
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL pd_err_clear: got %b want 0", err_o); end
        n_cmp++; if (grp_buf_size_o !== 7'd0) begin n_bad++; $display("FAIL pd_size_clear: got %0d want 0", grp_buf_size_o); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall_and_mask();
        test_skip();
        test_merge();
        test_reset_midframe();
        test_pad_and_trunc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
